ws2812_frame_tx: RTL and testbench
==================================

Name: ws2812_frame_tx

Overview:
Serial transmit stage that sits directly downstream of the 128-bit, 16-byte one-hot byte selector. It drives the one-hot select bus and captures each selected byte. It then shifts the byte out MSB-first as WS2812 NRZ pulse-width-coded bits, and ends each frame with a low latch/reset interval. The dout pin connects to the LED strip data line.

Parameters:
NUM_BYTES, 16, bytes per frame; legal range 1..16.
T0H_CYCLES, 20, high time of a '0' bit in clk cycles (0.4 us at 50 MHz).
T1H_CYCLES, 40, high time of a '1' bit in clk cycles (0.8 us at 50 MHz).
BIT_CYCLES, 63, total bit period in clk cycles (1.26 us at 50 MHz).
RESET_CYCLES, 3000, low latch time after the last bit (60 us at 50 MHz).
Legal values require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  frame request, sampled only in IDLE
byte_in  input  8  selected byte from the byte selector's data_out; combinational function of sel
sel  output  16  one-hot byte select; bit i selects byte i (data_in[8i+7:8i])
dout  output  1  WS2812 serial data line
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, any state): state=IDLE, sel=16'h0001, dout=0, busy=0, done=0, all counters=0. Takes effect immediately, including mid-bit; dout drops low without finishing the bit.
- All outputs are registered. States: IDLE, LOAD, BIT, LATCH.
- IDLE:
  - dout=0, busy=0, sel=16'h0001.
  - start=1 moves to LOAD on the next edge.
- LOAD (exactly 1 cycle, once per frame):
  - shreg <= byte_in (byte 0), bit_idx <= 7, cnt <= 0, byte_idx <= 0, busy=1.
  - Next state is BIT.
- BIT:
  - cnt runs 0..BIT_CYCLES-1.
  - dout=1 while cnt < (shreg[7] ? T1H_CYCLES : T0H_CYCLES), else dout=0.
  - At cnt==BIT_CYCLES-1, cnt wraps to 0, and:
    - bit_idx>0: shreg shifts left 1, bit_idx decrements.
    - bit_idx==0 and byte_idx<NUM_BYTES-1: shreg <= byte_in, bit_idx <= 7, byte_idx increments.
    - bit_idx==0 and byte_idx==NUM_BYTES-1: go to LATCH.
- sel prefetch:
  - On the edge where bit_idx goes 1->0 and byte_idx<NUM_BYTES-1, sel rotates left by one, so byte_in is stable for the whole of bit 0 before capture.
  - No gap cycles are inserted between bytes; bit periods are contiguous.
- sel range:
  - sel never has a bit set above position NUM_BYTES-1.
  - sel holds during the last byte.
  - sel returns to 16'h0001 on entry to LATCH.
- LATCH:
  - dout=0 for exactly RESET_CYCLES cycles, busy=1.
  - After the last latch cycle: done=1 for one cycle, busy=0, state=IDLE, all on the same edge.
- Timing:
  - start sampled at edge k gives LOAD in cycle k+1 and the first dout rise in cycle k+2.
  - Frame length from first dout rise to done: NUM_BYTES*8*BIT_CYCLES + RESET_CYCLES cycles.
- start handling:
  - start while busy (LOAD/BIT/LATCH) is ignored and not queued.
  - start asserted in the done cycle (already IDLE) is accepted, giving a back-to-back frame.
- Width rules:
  - cnt is sized ceil(log2(max(BIT_CYCLES, RESET_CYCLES)+1)) and is reused for the latch count.
  - byte_idx is 4 bits, bit_idx is 3 bits.
- byte_in changes outside the capture edges have no effect.

Test Plan:
1. NUM_BYTES=1, T0H=2, T1H=4, BIT=6, RESET=10; byte_in=0xA5, pulse start -> dout high-times 4,2,4,2,2,4,2,4 cycles in 6-cycle periods; 10 low cycles; done pulse 58 cycles after the first rise (48 bit cycles + 10 latch); busy low the same cycle.
2. NUM_BYTES=16, same timing; bench models the selector with byte i=i -> sel steps 0x0001..0x8000, advancing at bit 0 of each byte; decoded serial stream is 0x00..0x0F with no gaps; sel=0x0001 in LATCH.
3. Bytes 0x00 and 0xFF with NUM_BYTES=2 -> 8 pulses of 2 cycles, then 8 pulses of 4 cycles; period is 6 cycles everywhere, including the byte boundary.
4. Pulse start mid-frame and during LATCH -> no effect on waveform or frame length; exactly one done pulse.
5. Assert rst for 1 cycle during the dout-high portion of byte 3 -> dout=0, sel=0x0001, busy=0 immediately (asynchronously); a following start transmits a complete frame from byte 0.
6. Hold start high continuously -> frames repeat; each new LOAD occurs the cycle after done; dout stays low for exactly RESET_CYCLES between frames, plus the done cycle and the LOAD cycle.

Source files
------------

// File: rtl/ws2812_frame_tx.sv
// rtl/ws2812_frame_tx.sv - WS2812 NRZ frame transmitter driving a one-hot byte selector
module ws2812_frame_tx #(
    parameter int NUM_BYTES    = 16,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    output logic [15:0] sel,
    output logic        dout,
    output logic        busy,
    output logic        done
);

    // One counter serves both the bit period and the latch interval.
    localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
    localparam logic [3:0]    LAST_BYTE  = 4'(NUM_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_BIT   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [15:0]   sel_q, sel_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic; dout is derived from the next state so the pin is a flop output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sel_d  = 16'h0001;
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                shreg_d    = byte_in;
                bit_idx_d  = 3'd7;
                byte_idx_d = 4'd0;
                cnt_d      = '0;
                busy_d     = 1'b1;
                state_d    = S_BIT;
            end
            S_BIT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q - 3'd1;
                        // Advance the selector one bit early so byte_in settles before capture.
                        if (bit_idx_q == 3'd1 && byte_idx_q < LAST_BYTE) begin
                            sel_d = {sel_q[14:0], sel_q[15]};
                        end
                    end else if (byte_idx_q < LAST_BYTE) begin
                        shreg_d    = byte_in;
                        bit_idx_d  = 3'd7;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end else begin
                        state_d = S_LATCH;
                        sel_d   = 16'h0001;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        dout_d = (state_d == S_BIT) && (cnt_d < (shreg_d[7] ? T1H : T0H));
    end

    // State and output registers with immediate return to idle on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 4'd0;
            sel_q      <= 16'h0001;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            sel_q      <= sel_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel  = sel_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// tb/tb_ws2812_frame_tx.sv - scoreboard bench for ws2812_frame_tx at 16, 1 and 2 bytes per frame
module tb_ws2812_frame_tx;

    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int BITC = 6;
    localparam int RSTC = 10;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    bit   fin [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0d, expected %0d", inst, name, act, exp);
    endtask

    // Expected one-hot select while bit number bitn of the frame is on the wire.
    function automatic longint sel_exp(input int nb, input int bitn);
        int j;
        int idx;
        j   = bitn / 8;
        idx = j;
        if ((bitn % 8) == 7 && j < nb - 1) idx = j + 1;
        return longint'(1) << idx;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NB = (g == 0) ? 16 : ((g == 1) ? 1 : 2);

        logic        rst;
        logic        start;
        logic [7:0]  byte_in;
        logic [15:0] sel;
        logic        dout, busy, done;
        logic [7:0]  mem [16];

        logic [127:0] exp_data_q [$];
        int           exp_rise_q [$];

        // Byte selector model: OR of the bytes picked by sel.
        always_comb begin
            byte_in = 8'h00;
            for (int i = 0; i < 16; i++) if (sel[i]) byte_in = byte_in | mem[i];
        end

        ws2812_frame_tx #(
            .NUM_BYTES   (NB),
            .T0H_CYCLES  (T0H),
            .T1H_CYCLES  (T1H),
            .BIT_CYCLES  (BITC),
            .RESET_CYCLES(RSTC)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .byte_in(byte_in),
            .sel    (sel),
            .dout   (dout),
            .busy   (busy),
            .done   (done)
        );

        task automatic expect_frame();
            logic [127:0] d;
            d = '0;
            for (int i = 0; i < NB; i++) d = {d[119:0], mem[i]};
            exp_data_q.push_back(d);
            exp_rise_q.push_back(cyc + 2);
        endtask

        task automatic send(output int c0);
            expect_frame();
            c0    = cyc;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_done();
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < NB * 8 * BITC + RSTC + 40 && !seen; n++) begin
                @(negedge clk);
                seen = done;
            end
            chk(g, "done_within_bound", seen, 1);
        endtask

        task automatic randomize_mem();
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        endtask

        // Monitor: decode the pulse train and compare against the scoreboard.
        initial begin
            logic [127:0] got, ref_d;
            int  nbits, t_rise, first_rise, hi, dummy;
            bit  in_frame, prev_dout, prev_done;
            got = '0; nbits = 0; t_rise = 0; first_rise = 0;
            in_frame = 0; prev_dout = 0; prev_done = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    in_frame = 0; nbits = 0; prev_dout = 0; prev_done = 0;
                end else begin
                    if (dout && !prev_dout) begin
                        if (!in_frame) begin
                            chk(g, "frame_expected", exp_rise_q.size() > 0, 1);
                            if (exp_rise_q.size() > 0) chk(g, "first_rise_cycle", cyc, exp_rise_q[0]);
                            chk(g, "busy_in_frame", busy, 1);
                            in_frame = 1; nbits = 0; got = '0; first_rise = cyc;
                        end else begin
                            chk(g, "bit_period", cyc - t_rise, BITC);
                        end
                        chk(g, "sel_at_bit", sel, sel_exp(NB, nbits));
                        t_rise = cyc;
                    end
                    if (!dout && prev_dout && in_frame) begin
                        hi = cyc - t_rise;
                        chk(g, "high_time_legal", (hi == T0H) || (hi == T1H), 1);
                        got = {got[126:0], hi == T1H};
                        nbits++;
                    end
                    if (in_frame && cyc == first_rise + NB * 8 * BITC) begin
                        chk(g, "latch_sel", sel, 1);
                        chk(g, "latch_busy", busy, 1);
                        chk(g, "latch_dout", dout, 0);
                    end
                    if (done) begin
                        chk(g, "done_single_cycle", prev_done, 0);
                        chk(g, "done_expected", (exp_data_q.size() > 0) && in_frame, 1);
                        chk(g, "busy_at_done", busy, 0);
                        if (exp_data_q.size() > 0 && in_frame) begin
                            ref_d = exp_data_q.pop_front();
                            dummy = exp_rise_q.pop_front();
                            chk(g, "bit_count", nbits, NB * 8);
                            for (int i = 0; i < NB; i++)
                                chk(g, "byte_value", got[(NB-1-i)*8 +: 8], ref_d[(NB-1-i)*8 +: 8]);
                            chk(g, "frame_length", cyc - first_rise, NB * 8 * BITC + RSTC);
                        end
                        in_frame = 0;
                    end
                    prev_dout = dout;
                    prev_done = done;
                end
            end
        end

        // Stimulus sequence for this instance.
        initial begin
            int c0, jb, rises;
            bit hit, prevd;
            fin[g] = 1'b0;
            rst    = 1'b1;
            start  = 1'b0;
            for (int i = 0; i < 16; i++) mem[i] = 8'h00;
            repeat (3) @(negedge clk);
            chk(g, "reset_sel", sel, 16'h0001);
            chk(g, "reset_dout", dout, 0);
            chk(g, "reset_busy", busy, 0);
            chk(g, "reset_done", done, 0);
            rst = 1'b0;
            repeat (2) @(negedge clk);

            for (int i = 0; i < 16; i++) mem[i] = 8'(i);
            send(c0); wait_done();

            randomize_mem(); mem[0] = 8'h00; mem[1] = 8'hFF;
            send(c0); wait_done();

            for (int f = 0; f < 3; f++) begin
                randomize_mem(); send(c0); wait_done();
                repeat (3) @(negedge clk);
            end

            // start pulses mid-frame and in the latch, plus a byte_in change away from capture
            randomize_mem(); send(c0);
            while (cyc < c0 + 2 + NB * 24) @(negedge clk);
            mem[0] = ~mem[0];
            start = 1'b1; @(negedge clk); start = 1'b0;
            while (cyc < c0 + 2 + NB * 8 * BITC + 3) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            wait_done();
            repeat (20) @(negedge clk);
            chk(g, "idle_after_ignored_starts", busy, 0);

            // reset during the high portion of a bit in byte 3 (or the last byte)
            randomize_mem(); send(c0);
            jb = (NB > 3) ? 3 : NB - 1;
            rises = 0; prevd = 0; hit = 0;
            for (int n = 0; n < NB * 8 * BITC + 20 && !hit; n++) begin
                @(negedge clk);
                if (dout && !prevd) rises++;
                prevd = dout;
                if (rises == 8 * jb + 3 && dout) hit = 1;
            end
            chk(g, "reset_point_reached", hit, 1);
            #1 rst = 1'b1;
            #1;
            chk(g, "async_reset_dout", dout, 0);
            chk(g, "async_reset_sel", sel, 16'h0001);
            chk(g, "async_reset_busy", busy, 0);
            exp_data_q.delete();
            exp_rise_q.delete();
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);

            randomize_mem(); send(c0); wait_done();
            repeat (2) @(negedge clk);

            // start held high: the second frame is accepted in the done cycle
            randomize_mem(); expect_frame(); start = 1'b1;
            wait_done();
            randomize_mem(); expect_frame();
            repeat (5) @(negedge clk);
            start = 1'b0;
            wait_done();

            repeat (30) @(negedge clk);
            chk(g, "scoreboard_drained", exp_data_q.size(), 0);
            fin[g] = 1'b1;
        end
    end

    initial begin
        bit all;
        all = 1'b0;
        for (int n = 0; n < 60000 && !all; n++) begin
            @(negedge clk);
            all = fin[0] && fin[1] && fin[2];
        end
        chk(-1, "all_sequences_finished", all, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
